// File: rtl/positron_layer_sequencer_if.sv
// Handshake bundle between the layer sequencer, its positron array and the
// neighbouring layers. slave = sequencer side, master = environment side.
interface positron_layer_sequencer_if #(
    parameter int unsigned POSIT_WIDTH  = 4,
    parameter int unsigned NB_POSITRONS = 10
);
    logic                                  s_rts_i;
    logic                                  s_rtr_o;
    logic [POSIT_WIDTH-1:0]                s_data_i;
    logic                                  p_rts_o;
    logic                                  p_sow_o;
    logic                                  p_eow_o;
    logic [POSIT_WIDTH-1:0]                p_data_o;
    logic [NB_POSITRONS-1:0]               p_rtr_i;
    logic [NB_POSITRONS-1:0]               p_rts_i;
    logic [NB_POSITRONS*POSIT_WIDTH-1:0]   p_data_i;
    logic [NB_POSITRONS-1:0]               p_rtr_o;
    logic                                  m_rts_o;
    logic                                  m_rtr_i;
    logic                                  m_sow_o;
    logic                                  m_eow_o;
    logic [POSIT_WIDTH-1:0]                m_data_o;
    logic                                  done_o;

    modport slave (
        input  s_rts_i, s_data_i, p_rtr_i, p_rts_i, p_data_i, m_rtr_i,
        output s_rtr_o, p_rts_o, p_sow_o, p_eow_o, p_data_o, p_rtr_o,
               m_rts_o, m_sow_o, m_eow_o, m_data_o, done_o
    );

    modport master (
        output s_rts_i, s_data_i, p_rtr_i, p_rts_i, p_data_i, m_rtr_i,
        input  s_rtr_o, p_rts_o, p_sow_o, p_eow_o, p_data_o, p_rtr_o,
               m_rts_o, m_sow_o, m_eow_o, m_data_o, done_o
    );
endinterface

// File: rtl/positron_layer_sequencer.sv
// Fully-connected layer sequencer: broadcasts a framed activation window to
// all positrons, then collects one result per positron in index order.
module positron_layer_sequencer #(
    parameter int unsigned POSIT_WIDTH  = 4,
    parameter int unsigned NB_UPSTREAM  = 784,
    parameter int unsigned NB_POSITRONS = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    positron_layer_sequencer_if.slave     bus
);
    localparam int unsigned CNT_W = $clog2(NB_UPSTREAM);
    localparam int unsigned IDX_W = $clog2(NB_POSITRONS);

    typedef enum logic [1:0] {FEED, COLLECT, DRAIN} state_t;

    state_t                  r_state, w_next;
    logic [CNT_W-1:0]        r_in_cnt;
    logic [IDX_W-1:0]        r_out_idx;
    logic                    r_full;
    logic                    r_sow;
    logic                    r_eow;
    logic [POSIT_WIDTH-1:0]  r_data;

    logic                    w_all_rdy;
    logic                    w_xfer;
    logic                    w_sel_rdy;
    logic                    w_sel_rts;
    logic [POSIT_WIDTH-1:0]  w_sel_data;
    logic                    w_capture;
    logic                    w_accept;
    logic                    w_in_last;
    logic                    w_out_last;
    logic [NB_POSITRONS-1:0] w_p_rtr;

    assign w_all_rdy  = &bus.p_rtr_i;
    assign w_xfer     = (r_state == FEED) && bus.s_rts_i && w_all_rdy;
    assign w_in_last  = (r_in_cnt == CNT_W'(NB_UPSTREAM - 1));
    assign w_out_last = (r_out_idx == IDX_W'(NB_POSITRONS - 1));
    assign w_accept   = r_full && bus.m_rtr_i;
    // Output register may take a new result when empty or being drained this cycle.
    assign w_sel_rdy  = (r_state == COLLECT) && (!r_full || bus.m_rtr_i);
    assign w_capture  = w_sel_rts && w_sel_rdy;

    always_comb begin
        w_sel_rts  = 1'b0;
        w_sel_data = '0;
        w_p_rtr    = '0;
        for (int unsigned k = 0; k < NB_POSITRONS; k++) begin
            if (r_out_idx == IDX_W'(k)) begin
                w_sel_rts  = bus.p_rts_i[k];
                w_sel_data = bus.p_data_i[k*POSIT_WIDTH +: POSIT_WIDTH];
                w_p_rtr[k] = w_sel_rdy;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        bus.s_rtr_o  = 1'b0;
        bus.p_rts_o  = 1'b0;
        bus.p_sow_o  = 1'b0;
        bus.p_eow_o  = 1'b0;
        bus.p_data_o = '0;
        bus.done_o   = 1'b0;
        case (r_state)
            FEED: begin
                bus.s_rtr_o  = w_all_rdy;
                bus.p_rts_o  = bus.s_rts_i && w_all_rdy;
                bus.p_sow_o  = bus.p_rts_o && (r_in_cnt == '0);
                bus.p_eow_o  = bus.p_rts_o && w_in_last;
                bus.p_data_o = bus.s_data_i;
                if (w_xfer && w_in_last) w_next = COLLECT;
            end
            COLLECT: begin
                if (w_capture && w_out_last) w_next = DRAIN;
            end
            DRAIN: begin
                bus.done_o = w_accept;
                if (w_accept) w_next = FEED;
            end
            default: w_next = FEED;
        endcase
    end

    assign bus.p_rtr_o  = w_p_rtr;
    assign bus.m_rts_o  = r_full;
    assign bus.m_sow_o  = r_sow;
    assign bus.m_eow_o  = r_eow;
    assign bus.m_data_o = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= FEED;
            r_in_cnt  <= '0;
            r_out_idx <= '0;
            r_full    <= 1'b0;
            r_sow     <= 1'b0;
            r_eow     <= 1'b0;
            r_data    <= '0;
        end else begin
            r_state <= w_next;
            if (w_xfer) r_in_cnt <= w_in_last ? '0 : r_in_cnt + 1'b1;
            if (w_capture) begin
                r_out_idx <= w_out_last ? '0 : r_out_idx + 1'b1;
                r_full    <= 1'b1;
                r_sow     <= (r_out_idx == '0);
                r_eow     <= w_out_last;
                r_data    <= w_sel_data;
            end else if (w_accept) begin
                r_full <= 1'b0;
                r_sow  <= 1'b0;
                r_eow  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_positron_layer_sequencer.sv
// Directed bench for positron_layer_sequencer with a 4-word window and
// three positrons; expected values are worked out by hand per step.
module tb_positron_layer_sequencer;
    localparam int unsigned W  = 4;
    localparam int unsigned NU = 4;
    localparam int unsigned NP = 3;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    positron_layer_sequencer_if #(.POSIT_WIDTH(W), .NB_POSITRONS(NP)) ifc ();

    positron_layer_sequencer #(
        .POSIT_WIDTH (W),
        .NB_UPSTREAM (NU),
        .NB_POSITRONS(NP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Feeds one full window without checks (all positrons ready).
    task automatic feed_frame(input logic [W-1:0] base);
        for (int i = 0; i < int'(NU); i++) begin
            ifc.s_rts_i  = 1'b1;
            ifc.s_data_i = base + W'(i);
            tick();
        end
        ifc.s_rts_i = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n        = 1'b0;
        ifc.s_rts_i  = 1'b0;
        ifc.s_data_i = '0;
        ifc.p_rtr_i  = 3'b111;
        ifc.p_rts_i  = '0;
        ifc.p_data_i = '0;
        ifc.m_rtr_i  = 1'b0;
        #12;
        chk("rst_m_rts", ifc.m_rts_o, 0);
        chk("rst_m_sow", ifc.m_sow_o, 0);
        chk("rst_m_eow", ifc.m_eow_o, 0);
        chk("rst_m_data", ifc.m_data_o, 0);
        chk("rst_done", ifc.done_o, 0);
        chk("rst_p_rtr", ifc.p_rtr_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Frame 1 feed: words 1,2 then a 3-cycle stall on positron 2, then 3,4
        ifc.s_rts_i = 1'b1; ifc.s_data_i = 4'd1; settle();
        chk("w1_s_rtr", ifc.s_rtr_o, 1);
        chk("w1_p_rts", ifc.p_rts_o, 1);
        chk("w1_sow", ifc.p_sow_o, 1);
        chk("w1_eow", ifc.p_eow_o, 0);
        chk("w1_data", ifc.p_data_o, 1);
        tick();
        ifc.s_data_i = 4'd2; settle();
        chk("w2_sow", ifc.p_sow_o, 0);
        chk("w2_data", ifc.p_data_o, 2);
        tick();
        ifc.s_data_i = 4'd3; ifc.p_rtr_i = 3'b011;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("stall_s_rtr", ifc.s_rtr_o, 0);
            chk("stall_p_rts", ifc.p_rts_o, 0);
            tick();
        end
        ifc.p_rtr_i = 3'b111; settle();
        chk("w3_p_rts", ifc.p_rts_o, 1);
        chk("w3_sow", ifc.p_sow_o, 0);
        chk("w3_eow", ifc.p_eow_o, 0);
        chk("w3_data", ifc.p_data_o, 3);
        tick();
        ifc.s_data_i = 4'd4; settle();
        chk("w4_eow", ifc.p_eow_o, 1);
        chk("w4_data", ifc.p_data_o, 4);
        tick();

        // Frame 1 collect: all results ready, downstream always ready
        ifc.p_rts_i = 3'b111; ifc.p_data_i = 12'h765; ifc.m_rtr_i = 1'b1; settle();
        chk("col_s_rtr", ifc.s_rtr_o, 0);
        chk("col_p_rts", ifc.p_rts_o, 0);
        chk("c0_p_rtr", ifc.p_rtr_o, 3'b001);
        chk("c0_m_rts", ifc.m_rts_o, 0);
        ifc.s_rts_i = 1'b0;
        tick();
        chk("c1_m_rts", ifc.m_rts_o, 1);
        chk("c1_data", ifc.m_data_o, 5);
        chk("c1_sow", ifc.m_sow_o, 1);
        chk("c1_eow", ifc.m_eow_o, 0);
        chk("c1_p_rtr", ifc.p_rtr_o, 3'b010);
        chk("c1_done", ifc.done_o, 0);
        tick();
        chk("c2_m_rts", ifc.m_rts_o, 1);
        chk("c2_data", ifc.m_data_o, 6);
        chk("c2_sow", ifc.m_sow_o, 0);
        chk("c2_p_rtr", ifc.p_rtr_o, 3'b100);
        tick();
        chk("c3_data", ifc.m_data_o, 7);
        chk("c3_eow", ifc.m_eow_o, 1);
        chk("c3_done", ifc.done_o, 1);
        chk("c3_p_rtr", ifc.p_rtr_o, 0);
        chk("c3_s_rtr", ifc.s_rtr_o, 0);
        tick();
        chk("c4_m_rts", ifc.m_rts_o, 0);
        chk("c4_eow", ifc.m_eow_o, 0);
        chk("c4_data_hold", ifc.m_data_o, 7);
        chk("c4_done", ifc.done_o, 0);
        chk("c4_s_rtr", ifc.s_rtr_o, 1);

        // Frame 2: only positron 2 valid at first, order must stay 0,1,2
        ifc.p_rts_i = '0;
        ifc.s_rts_i = 1'b1; ifc.s_data_i = 4'd8; settle();
        chk("f2_sow", ifc.p_sow_o, 1);
        feed_frame(4'd8);
        ifc.p_rts_i = 3'b100; ifc.p_data_i = 12'hABC; settle();
        chk("o0_p_rtr", ifc.p_rtr_o, 3'b001);
        tick(); tick();
        chk("o0_no_cap", ifc.m_rts_o, 0);
        chk("o0_p_rtr2", ifc.p_rtr_o, 3'b001);
        ifc.p_rts_i = 3'b101;
        tick();
        chk("o1_m_rts", ifc.m_rts_o, 1);
        chk("o1_data", ifc.m_data_o, 4'hC);
        chk("o1_sow", ifc.m_sow_o, 1);
        chk("o1_p_rtr", ifc.p_rtr_o, 3'b010);
        tick();
        chk("o2_m_rts", ifc.m_rts_o, 0);
        chk("o2_data_hold", ifc.m_data_o, 4'hC);
        chk("o2_sow", ifc.m_sow_o, 0);
        chk("o2_p_rtr", ifc.p_rtr_o, 3'b010);
        ifc.p_rts_i = 3'b111;
        tick();
        chk("o3_data", ifc.m_data_o, 4'hB);
        chk("o3_p_rtr", ifc.p_rtr_o, 3'b100);
        tick();
        chk("o4_data", ifc.m_data_o, 4'hA);
        chk("o4_eow", ifc.m_eow_o, 1);
        chk("o4_done", ifc.done_o, 1);
        tick();

        // Frame 3: downstream back-pressure for 5 cycles after the first capture
        ifc.p_rts_i = '0;
        feed_frame(4'd0);
        ifc.p_rts_i = 3'b111; ifc.p_data_i = 12'h432; ifc.m_rtr_i = 1'b0; settle();
        chk("b0_p_rtr", ifc.p_rtr_o, 3'b001);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_m_rts", ifc.m_rts_o, 1);
            chk("bp_data", ifc.m_data_o, 2);
            chk("bp_sow", ifc.m_sow_o, 1);
            chk("bp_p_rtr", ifc.p_rtr_o, 0);
            tick();
        end
        ifc.m_rtr_i = 1'b1; settle();
        chk("br_p_rtr", ifc.p_rtr_o, 3'b010);
        tick();
        chk("b1_data", ifc.m_data_o, 3);
        chk("b1_sow", ifc.m_sow_o, 0);
        tick();
        chk("b2_data", ifc.m_data_o, 4);
        chk("b2_eow", ifc.m_eow_o, 1);
        chk("b2_done", ifc.done_o, 1);
        tick();

        // Asynchronous reset in the middle of a window
        ifc.p_rts_i = '0;
        ifc.s_rts_i = 1'b1; ifc.s_data_i = 4'd1; tick();
        ifc.s_data_i = 4'd2; tick();
        ifc.s_data_i = 4'd3; settle();
        chk("mid_sow", ifc.p_sow_o, 0);
        #2;
        rst_n = 1'b0; ifc.s_rts_i = 1'b0;
        #1;
        chk("ar_m_rts", ifc.m_rts_o, 0);
        chk("ar_m_data", ifc.m_data_o, 0);
        chk("ar_m_eow", ifc.m_eow_o, 0);
        chk("ar_done", ifc.done_o, 0);
        chk("ar_p_rts", ifc.p_rts_o, 0);
        chk("ar_p_rtr", ifc.p_rtr_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        ifc.s_rts_i = 1'b1; ifc.s_data_i = 4'd9; settle();
        chk("post_rst_sow", ifc.p_sow_o, 1);
        chk("post_rst_data", ifc.p_data_o, 9);
        tick();
        ifc.s_rts_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
